data_reshuffler_stream: RTL and testbench

- Multi-mode, batch-controlled successor to the single-shot transpose reshuffler.
- Takes a SpatPar x SpatPar tile of Elems-bit elements per beat and applies one of four permutations: bypass, transpose, row-reverse or column-reverse.
- Buffers results in a FifoDepth-entry output FIFO, so a streamer-side stall does not cost throughput.
- A CSR-programmed block count frames each job; a small FSM accepts new configuration only when idle.

---
 rtl/data_reshuffler_stream.sv | 177 +++++++++++++++++
 tb/tb_data_reshuffler_stream.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_reshuffler_stream.sv
// Streaming tile reshuffler: bypass/transpose/row-reverse/column-reverse, output FIFO, CSR-framed jobs.
// Optional stall counter enabled by defining DATA_RESHUFFLER_STREAM_PERF_EN.
module data_reshuffler_stream #(
    parameter int unsigned SpatPar   = 8,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Elems     = DataWidth / SpatPar,
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [SpatPar*DataWidth-1:0]   a_i,
    input  logic                           a_valid_i,
    output logic                           a_ready_o,
    output logic [SpatPar*DataWidth-1:0]   z_o,
    output logic                           z_valid_o,
    input  logic                           z_ready_i,
    input  logic [1:0]                     csr_mode_i,
    input  logic [CntWidth-1:0]            csr_num_blocks_i,
    input  logic                           csr_valid_i,
    output logic                           csr_ready_o,
    output logic                           busy_o,
    output logic [CntWidth-1:0]            perf_stall_o
);

    localparam int unsigned TileW = SpatPar * DataWidth;
    localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned OccW  = $clog2(FifoDepth + 1);

    localparam logic [1:0] ModeTranspose = 2'd1;
    localparam logic [1:0] ModeRowRev    = 2'd2;
    localparam logic [1:0] ModeColRev    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DRAIN
    } state_e;

    state_e              state_q;
    logic [1:0]          mode_q;
    logic [CntWidth-1:0] num_blocks_q;
    logic [CntWidth-1:0] beat_q;
    logic [CntWidth-1:0] beat_inc_c;

    logic [TileW-1:0]    perm_c;
    logic [TileW-1:0]    mem_q [FifoDepth];
    logic [TileW-1:0]    last_q;
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [OccW-1:0]     occ_q;
    logic [OccW-1:0]     occ_d;
    logic                full_c;
    logic                empty_c;
    logic                push_c;
    logic                pop_c;

    // Element permutation selected by the mode latched for the current job
    for (genvar i = 0; i < SpatPar; i++) begin : g_row
        for (genvar j = 0; j < SpatPar; j++) begin : g_col
            localparam int unsigned Dst = (i * SpatPar + j) * Elems;
            localparam int unsigned Tr  = (j * SpatPar + i) * Elems;
            localparam int unsigned Rr  = ((SpatPar - 1 - i) * SpatPar + j) * Elems;
            localparam int unsigned Cr  = (i * SpatPar + (SpatPar - 1 - j)) * Elems;
            assign perm_c[Dst +: Elems] =
                (mode_q == ModeTranspose) ? a_i[Tr +: Elems] :
                (mode_q == ModeRowRev)    ? a_i[Rr +: Elems] :
                (mode_q == ModeColRev)    ? a_i[Cr +: Elems] :
                                            a_i[Dst +: Elems];
        end
    end

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_c      = (occ_q == OccW'(FifoDepth));
    assign empty_c     = (occ_q == '0);
    assign pop_c       = !empty_c && z_ready_i;
    assign a_ready_o   = (state_q == ST_BUSY) && (!full_c || z_ready_i);
    assign push_c      = a_valid_i && a_ready_o;
    assign z_valid_o   = !empty_c;
    assign z_o         = empty_c ? last_q : mem_q[rd_ptr_q];
    assign csr_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign beat_inc_c  = beat_q + CntWidth'(1);

    always_comb begin
        occ_d = occ_q;
        if (push_c && !pop_c) begin
            occ_d = occ_q + OccW'(1);
        end else if (!push_c && pop_c) begin
            occ_d = occ_q - OccW'(1);
        end
    end

    // Job control: configuration is only taken while idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mode_q       <= '0;
            num_blocks_q <= '0;
            beat_q       <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (csr_valid_i) begin
                        mode_q       <= csr_mode_i;
                        num_blocks_q <= csr_num_blocks_i;
                        beat_q       <= '0;
                        if (csr_num_blocks_i != '0) begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (push_c) begin
                        beat_q <= beat_inc_c;
                        if (beat_inc_c == num_blocks_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (occ_d == '0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            last_q   <= '0;
        end else begin
            occ_q <= occ_d;
            if (push_c) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop_c) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= perm_c;
        end
    end

`ifdef DATA_RESHUFFLER_STREAM_PERF_EN
    logic [CntWidth-1:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if ((state_q == ST_IDLE) && csr_valid_i) begin
            stall_q <= '0;
        end else if (z_valid_o && !z_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + CntWidth'(1);
        end
    end

    assign perf_stall_o = stall_q;
`else
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_data_reshuffler_stream.sv
// Directed + randomized bench for data_reshuffler_stream with a queue-based reference model.
module tb_data_reshuffler_stream;

    localparam int unsigned SP = 8;
    localparam int unsigned DW = 64;
    localparam int unsigned EW = DW / SP;
    localparam int unsigned TW = SP * DW;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [TW-1:0] a_i;
    logic          a_valid_i;
    logic          a_ready_o;
    logic [TW-1:0] z_o;
    logic          z_valid_o;
    logic          z_ready_i;
    logic [1:0]    csr_mode_i;
    logic [CW-1:0] csr_num_blocks_i;
    logic          csr_valid_i;
    logic          csr_ready_o;
    logic          busy_o;
    logic [CW-1:0] perf_stall_o;

    data_reshuffler_stream dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .a_i              (a_i),
        .a_valid_i        (a_valid_i),
        .a_ready_o        (a_ready_o),
        .z_o              (z_o),
        .z_valid_o        (z_valid_o),
        .z_ready_i        (z_ready_i),
        .csr_mode_i       (csr_mode_i),
        .csr_num_blocks_i (csr_num_blocks_i),
        .csr_valid_i      (csr_valid_i),
        .csr_ready_o      (csr_ready_o),
        .busy_o           (busy_o),
        .perf_stall_o     (perf_stall_o)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            n_acc;
    int            n_out;
    int            stall_cnt;
    logic          acc_flag;
    logic          ar_seen;
    logic [1:0]    job_mode;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] last_out;
    logic [TW-1:0] pat;

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: view the tile as a 2-D element grid and read out the selected permutation
    function automatic logic [TW-1:0] model(input logic [TW-1:0] a, input logic [1:0] m);
        logic [EW-1:0] e [SP][SP];
        logic [TW-1:0] z;
        for (int r = 0; r < SP; r++)
            for (int c = 0; c < SP; c++)
                e[r][c] = a[(r*SP+c)*EW +: EW];
        z = '0;
        for (int r = 0; r < SP; r++)
            for (int c = 0; c < SP; c++)
                case (m)
                    2'd1:    z[(r*SP+c)*EW +: EW] = e[c][r];
                    2'd2:    z[(r*SP+c)*EW +: EW] = e[SP-1-r][c];
                    2'd3:    z[(r*SP+c)*EW +: EW] = e[r][SP-1-c];
                    default: z[(r*SP+c)*EW +: EW] = e[r][c];
                endcase
        return z;
    endfunction

    function automatic logic [TW-1:0] rand_tile();
        logic [TW-1:0] t;
        for (int k = 0; k < TW / 32; k++) t[k*32 +: 32] = $urandom;
        return t;
    endfunction

    // One clock: observe handshakes just before the edge, update the scoreboard, advance
    task automatic cycle();
        logic [TW-1:0] exp_t;
        #1;
        ar_seen = a_ready_o;
        if (z_valid_o && z_ready_i) begin
            if (exp_q.size() == 0) begin
                check("z_unexpected", TW'(z_valid_o), TW'(0));
            end else begin
                exp_t = exp_q.pop_front();
                check("z_data", z_o, exp_t);
                last_out = exp_t;
            end
            n_out++;
        end
        if (z_valid_o && !z_ready_i) stall_cnt++;
        acc_flag = a_valid_i && a_ready_o;
        if (acc_flag) begin
            exp_q.push_back(model(a_i, job_mode));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed_cycle();
        cycle();
        if (acc_flag) a_i = rand_tile();
    endtask

    task automatic cfg(input logic [1:0] m, input logic [CW-1:0] nb);
        csr_mode_i       = m;
        csr_num_blocks_i = nb;
        csr_valid_i      = 1'b1;
        #1;
        check("cfg_ready", TW'(csr_ready_o), TW'(1));
        job_mode  = m;
        n_acc     = 0;
        n_out     = 0;
        stall_cnt = 0;
        @(posedge clk);
        #1;
        csr_valid_i = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        int c;
        c = 0;
        while (busy_o && c < budget) begin
            feed_cycle();
            c++;
        end
        check("idle_timeout", TW'(busy_o), TW'(0));
    endtask

    initial begin
        int cyc;
        int drops;
        logic in_busy;
        logic [7:0] b0;
        logic [CW-1:0] nb;

        rst_i            = 1'b1;
        a_i              = '0;
        a_valid_i        = 1'b0;
        z_ready_i        = 1'b0;
        csr_mode_i       = '0;
        csr_num_blocks_i = '0;
        csr_valid_i      = 1'b0;
        job_mode         = '0;
        last_out         = '0;
        n_acc = 0; n_out = 0; stall_cnt = 0;
        for (int k = 0; k < 64; k++) pat[k*8 +: 8] = 8'(k);

        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", TW'(a_ready_o), TW'(0));
        check("rst_z_valid", TW'(z_valid_o), TW'(0));
        check("rst_z", z_o, TW'(0));
        check("rst_csr_ready", TW'(csr_ready_o), TW'(1));
        check("rst_busy", TW'(busy_o), TW'(0));
        check("rst_perf", TW'(perf_stall_o), TW'(0));
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Transpose, single beat, one-cycle latency
        cfg(2'd1, 1);
        check("tr_busy", TW'(busy_o), TW'(1));
        check("tr_csr_ready", TW'(csr_ready_o), TW'(0));
        a_i = pat; a_valid_i = 1'b1; z_ready_i = 1'b1;
        cycle();
        check("tr_a_ready", TW'(ar_seen), TW'(1));
        a_valid_i = 1'b0;
        check("tr_z_valid", TW'(z_valid_o), TW'(1));
        check("tr_byte1", TW'(z_o[15:8]), TW'(8'h08));
        check("tr_byte8", TW'(z_o[71:64]), TW'(8'h01));
        check("tr_byte63", TW'(z_o[511:504]), TW'(8'h3F));
        cycle();
        check("tr_busy_fall", TW'(busy_o), TW'(0));
        check("tr_z_valid_fall", TW'(z_valid_o), TW'(0));
        check("tr_z_hold", z_o, last_out);

        // Reverse modes and bypass on the byte pattern
        for (int m = 2; m <= 4; m++) begin
            cfg(2'(m % 4), 1);
            a_i = pat; a_valid_i = 1'b1;
            cycle();
            a_valid_i = 1'b0;
            b0 = (m == 2) ? 8'h38 : (m == 3) ? 8'h07 : 8'h00;
            check("rev_byte0", TW'(z_o[7:0]), TW'(b0));
            if (m == 4) check("bypass_tile", z_o, pat);
            cycle();
            check("rev_busy_fall", TW'(busy_o), TW'(0));
        end

        // Backpressure: FIFO fills, then a_ready_o follows z_ready_i
        cfg(2'd0, 4);
        z_ready_i = 1'b0; a_valid_i = 1'b1; a_i = rand_tile();
        repeat (6) feed_cycle();
        check("bp_accepted", TW'(n_acc), TW'(2));
        check("bp_a_ready", TW'(a_ready_o), TW'(0));
        // CSR write while busy must be ignored
        csr_mode_i = 2'd2; csr_num_blocks_i = 5; csr_valid_i = 1'b1;
        #1;
        check("gate_csr_ready", TW'(csr_ready_o), TW'(0));
        feed_cycle();
        csr_valid_i = 1'b0;
        check("gate_busy", TW'(busy_o), TW'(1));
`ifdef DATA_RESHUFFLER_STREAM_PERF_EN
        check("bp_perf", TW'(perf_stall_o), TW'(stall_cnt));
`else
        check("bp_perf_off", TW'(perf_stall_o), TW'(0));
`endif
        z_ready_i = 1'b1;
        run_idle(50);
        a_valid_i = 1'b0;
        check("bp_outputs", TW'(n_out), TW'(4));
        check("bp_queue_empty", TW'(exp_q.size()), TW'(0));
`ifdef DATA_RESHUFFLER_STREAM_PERF_EN
        check("bp_perf_end", TW'(perf_stall_o), TW'(stall_cnt));
`endif

        // After draining, the previously refused write is accepted
        cfg(2'd2, 1);
        a_i = rand_tile(); a_valid_i = 1'b1;
        run_idle(20);
        a_valid_i = 1'b0;
        check("gate_outputs", TW'(n_out), TW'(1));

        // Zero-length job is a no-op
        cfg(2'd1, 0);
        check("zero_busy", TW'(busy_o), TW'(0));
        check("zero_csr_ready", TW'(csr_ready_o), TW'(1));

        // Full-rate streaming: 16 tiles in 17 cycles
        cfg(2'($urandom_range(0, 3)), 16);
        a_valid_i = 1'b1; z_ready_i = 1'b1; a_i = rand_tile();
        cyc = 0; drops = 0;
        while (busy_o && cyc < 100) begin
            in_busy = (n_acc < 16);
            feed_cycle();
            if (in_busy && !ar_seen) drops++;
            cyc++;
        end
        a_valid_i = 1'b0;
        check("stream_cycles", TW'(cyc), TW'(17));
        check("stream_outputs", TW'(n_out), TW'(16));
        check("stream_ready_drops", TW'(drops), TW'(0));

        // Randomized jobs with random valid/ready patterns
        for (int j = 0; j < 4; j++) begin
            nb = CW'($urandom_range(1, 6));
            cfg(2'($urandom_range(0, 3)), nb);
            a_i = rand_tile();
            cyc = 0;
            while (busy_o && cyc < 300) begin
                a_valid_i = ($urandom_range(0, 3) != 0);
                z_ready_i = ($urandom_range(0, 2) != 0);
                feed_cycle();
                cyc++;
            end
            a_valid_i = 1'b0;
            check("rand_idle", TW'(busy_o), TW'(0));
            check("rand_outputs", TW'(n_out), TW'(nb));
            check("rand_hold", z_o, last_out);
        end

        // Reset in the middle of a job drops everything
        cfg(2'd1, 8);
        a_valid_i = 1'b1; z_ready_i = 1'b1; a_i = rand_tile();
        cyc = 0;
        while (n_acc < 3 && cyc < 20) begin
            feed_cycle();
            cyc++;
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        check("mid_rst_z_valid", TW'(z_valid_o), TW'(0));
        check("mid_rst_a_ready", TW'(a_ready_o), TW'(0));
        check("mid_rst_busy", TW'(busy_o), TW'(0));
        check("mid_rst_csr_ready", TW'(csr_ready_o), TW'(1));
        check("mid_rst_perf", TW'(perf_stall_o), TW'(0));
        a_valid_i = 1'b0;
        cycle();
        check("mid_rst_no_output", TW'(z_valid_o), TW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
